// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the funct3 opcodes, the FSM state type and the divide-class helper.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/rv_muldiv_sign_fix.sv
// Conditional two's-complement negate: out = neg ? -in : in (modulo 2^W).
module sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         neg_i,
    output logic [W-1:0] out_o
);

    assign out_o = neg_i ? ({W{1'b0}} - in_i) : in_i;

endmodule

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied on the finishing edge.
module rv_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign sa       = a_signed & a[XLEN-1];
    assign sb       = b_signed & b[XLEN-1];

    sign_fix #(.W(XLEN)) u_abs_a (.in_i(a), .neg_i(sa), .out_o(abs_a));
    sign_fix #(.W(XLEN)) u_abs_b (.in_i(b), .neg_i(sb), .out_o(abs_b));

    // Divides that need no iteration are answered directly in the load cycle.
    assign div_zero    = (b == {XLEN{1'b0}});
    assign div_ovf     = !funct3[0] && (a == MIN_VAL) && (b == {XLEN{1'b1}});
    assign special     = is_div(funct3) && (div_zero || div_ovf);
    assign special_res = div_zero ? (funct3[1] ? a : {XLEN{1'b1}})
                                  : (funct3[1] ? {XLEN{1'b0}} : MIN_VAL);

    logic [XLEN:0]     mul_sum, div_tmp, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, iter_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Shifted partial remainder is at most 2*divisor-1, so the borrow is bit XLEN.
    assign div_tmp  = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_tmp - {1'b0, opnd_q};
    assign div_next = div_diff[XLEN] ? {div_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign iter_next = is_div(op_q) ? div_next : mul_next;

    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_sel, div_fixed, final_res;

    assign div_sel = op_q[1] ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];

    sign_fix #(.W(2*XLEN)) u_fix_prod (.in_i(iter_next), .neg_i(neg_q), .out_o(prod_fixed));
    sign_fix #(.W(XLEN))   u_fix_div  (.in_i(div_sel),   .neg_i(neg_q), .out_o(div_fixed));

    assign final_res = is_div(op_q)        ? div_fixed :
                       (op_q == F3_MUL)    ? prod_fixed[XLEN-1:0] :
                                             prod_fixed[2*XLEN-1:XLEN];

    // start is taken in IDLE or DONE unless kill is high; while an accepted
    // request is iterating, stall holds the pipeline and further starts are dropped.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_d   = funct3;
                    opnd_d = abs_b;
                    acc_d  = {{XLEN{1'b0}}, abs_a};
                    neg_d  = (is_div(funct3) && funct3[1]) ? sa : (sa ^ sb);
                    if (special) begin
                        state_d  = DONE;
                        result_d = special_res;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(XLEN);
                    end
                end
            end
            CALC: begin
                acc_d = iter_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    result_d = final_res;
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign stall  = (state_q == CALC) | (start & (state_q != CALC) & !kill & !special);
    assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Self-checking bench for rv_muldiv: directed cases plus randomized operations
// compared every cycle against a latency/arithmetic model of the unit.
module tb_rv_muldiv;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic            clk, rst, start, kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a, b;
    logic            busy, stall, done;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;
    bit armed  = 0;

    rv_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
        .kill(kill), .busy(busy), .stall(stall), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint sx, sy, uy;
        int ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'b0, y});
        ix = int'(x);
        iy = int'(y);
        p  = 64'b0;
        case (f)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ix / iy);
            end
            3'd5: begin
                if (y == 0) return 32'hFFFFFFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return 32'(ix % iy);
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: an accepted normal op completes LAT cycles after its start edge,
    // a special divide one cycle after; kill/rst discard the pending op.
    bit          m_pend = 0;
    bit          m_done = 0;
    int          m_left = 0;
    logic [31:0] m_res = 32'h0;
    logic [31:0] m_pend_res = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 0; m_done = 0; m_res = 32'h0; m_left = 0;
        end else if (kill) begin
            m_pend = 0; m_done = 0;
        end else if (m_pend) begin
            m_left--;
            m_done = 0;
            if (m_left == 0) begin
                m_pend = 0; m_done = 1; m_res = m_pend_res;
            end
        end else if (start) begin
            if (is_special(funct3, a, b)) begin
                m_done = 1; m_res = ref_op(funct3, a, b);
            end else begin
                m_pend = 1; m_left = XLEN; m_pend_res = ref_op(funct3, a, b); m_done = 0;
            end
        end else begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy",   32'(busy),  32'(m_pend));
            check("done",   32'(done),  32'(m_done));
            check("stall",  32'(stall),
                  32'(m_pend | (start & !m_pend & !kill & !is_special(funct3, a, b))));
            check("result", result, m_res);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; funct3 = f; a = x; b = y;
        step();
        start = 1'b0;
    endtask

    task automatic expect_done(input string name, input logic [31:0] lit, input int lat, input int n0);
        int n;
        bit seen;
        n = n0;
        seen = 0;
        while (!seen && n <= 100) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin step(); n++; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s timeout: no done within 100 cycles, expected latency %0d", name, lat);
        end else begin
            check({name, "_lat"}, 32'(n), 32'(lat));
            check(name, result, lit);
            step();
        end
    endtask

    task automatic count_dones(input int ncyc, output int c);
        c = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (done) c++;
            step();
        end
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c;
        logic [2:0]  f;
        logic [31:0] x, y;
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; a = '0; b = '0;
        step();
        step();
        armed = 1;
        @(negedge clk);
        check("reset_busy",   32'(busy),  32'h0);
        check("reset_stall",  32'(stall), 32'h0);
        check("reset_done",   32'(done),  32'h0);
        check("reset_result", result,     32'h0);
        step();
        rst = 1'b0;

        check("pin_mul",    ref_op(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        check("pin_mulhsu", ref_op(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
        check("pin_div",    ref_op(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
        check("pin_rem",    ref_op(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

        issue(3'd0, 32'd7, 32'hFFFFFFFD);        expect_done("mul_neg",  32'hFFFFFFEB, LAT, 1);
        issue(3'd1, 32'h80000000, 32'h80000000); expect_done("mulh_min", 32'h40000000, LAT, 1);
        issue(3'd3, 32'h80000000, 32'h80000000); expect_done("mulhu",    32'h40000000, LAT, 1);
        issue(3'd2, 32'hFFFFFFFF, 32'd2);        expect_done("mulhsu",   32'hFFFFFFFF, LAT, 1);
        issue(3'd4, 32'hFFFFFFF9, 32'd2);        expect_done("div_neg",  32'hFFFFFFFD, LAT, 1);
        issue(3'd6, 32'hFFFFFFF9, 32'd2);        expect_done("rem_neg",  32'hFFFFFFFF, LAT, 1);
        issue(3'd5, 32'd100, 32'd7);             expect_done("divu",     32'd14,       LAT, 1);
        issue(3'd7, 32'd100, 32'd7);             expect_done("remu",     32'd2,        LAT, 1);
        issue(3'd5, 32'd5, 32'd0);               expect_done("divu_z",   32'hFFFFFFFF, 1, 1);
        issue(3'd7, 32'd5, 32'd0);               expect_done("remu_z",   32'd5,        1, 1);
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF); expect_done("div_ovf",  32'h80000000, 1, 1);
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF); expect_done("rem_ovf",  32'h0,        1, 1);

        issue(3'd4, 32'd1000, 32'd3);
        repeat (9) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        @(negedge clk);
        check("kill_busy", 32'(busy), 32'h0);
        step();
        count_dones(40, c);
        check("kill_no_done", 32'(c), 32'h0);
        check("kill_result", result, 32'h0);
        issue(3'd0, 32'd3, 32'd4);               expect_done("mul_after_kill", 32'd12, LAT, 1);

        issue(3'd0, 32'd5, 32'd6);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   32'(busy),  32'h0);
        check("rst_stall",  32'(stall), 32'h0);
        check("rst_done",   32'(done),  32'h0);
        check("rst_result", result,     32'h0);
        step();

        start = 1'b1; funct3 = 3'd0; a = 32'd2; b = 32'd3;
        step();
        expect_done("b2b_first", 32'd6, LAT, 1);
        start = 1'b0;
        expect_done("b2b_second", 32'd6, LAT, 1);

        issue(3'd0, 32'd9, 32'd9);
        repeat (5) step();
        start = 1'b1; funct3 = 3'd5; a = 32'd10; b = 32'd0;
        step();
        start = 1'b0;
        expect_done("ignored_start", 32'd81, LAT, 7);
        count_dones(40, c);
        check("ignored_no_done", 32'(c), 32'h0);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) step();
            f = 3'($urandom_range(0, 7));
            x = rand_opnd();
            y = rand_opnd();
            issue(f, x, y);
            if (!is_special(f, x, y) && $urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 30)) step();
                kill = 1'b1;
                step();
                kill = 1'b0;
                step();
            end else begin
                expect_done($sformatf("rand%0d_f%0d", i, f), ref_op(f, x, y),
                            is_special(f, x, y) ? 1 : LAT, 1);
            end
        end

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
